dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Memory-stage load/store controller.
- Sequences one data-memory transaction per load/store: issues a request on a valid/ready request channel, waits for the response, and stalls the pipeline until the operation completes.
- Formats store data and byte enables. Aligns and extends load data.
- Drives the select of the M-stage output mux that chooses between execute data and memory response data.

Parameters:
- DATA_W, 32 (N_BITS): data and address width. Only 32 is supported.
- BE_W, 4: byte-enable width, equal to DATA_W/8.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  memory op present in M stage; held stable while stall=1
- op_we  in  1  1=store, 0=load
- op_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- op_unsigned  in  1  zero-extend loads (LBU/LHU)
- op_addr  in  32  byte address
- op_wdata  in  32  store data, right-justified
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  {op_addr[31:2],2'b00}
- mem_req_we  out  1  write enable
- mem_req_be  out  4  byte enables
- mem_req_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  read response valid, one-cycle pulse
- mem_rsp_data  in  32  read response word
- stall  out  1  hold upstream pipeline
- ld_data  out  32  aligned/extended load result
- ld_data_valid  out  1  one-cycle pulse with ld_data
- wb_sel  out  1  M-stage mux select (1 = load result)
- misaligned  out  1  one-cycle exception pulse

Behaviour:
- One clock, clk. rst_n is asynchronous, active-low.
- Reset: state=IDLE. All outputs 0. Internal op registers 0.
- Alignment check:
  - Misaligned if half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Misaligned ops never issue a memory request.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - op_valid & aligned: register op fields, stall=1 (combinational), go to REQ.
  - op_valid & misaligned: misaligned=1 this cycle, stall=0, stay in IDLE.
  - Otherwise stay in IDLE with stall=0.
- REQ:
  - mem_req_valid=1. addr/we/be/wdata come from registers and stay stable until handshake. stall=1.
  - valid&ready: store goes to DONE, load goes to WAIT_RSP.
  - ready low: hold all request outputs and stay in REQ.
- WAIT_RSP:
  - mem_req_valid=0, stall=1.
  - On mem_rsp_valid: capture the formatted load data, go to DONE.
- DONE:
  - stall=0.
  - Load: ld_data_valid=1, wb_sel=1, ld_data presented.
  - Store: ld_data_valid=0, wb_sel=0.
  - Always go to IDLE. op_valid seen in DONE belongs to the completing op and is not re-accepted. This gives one bubble between back-to-back memory ops.
- wb_sel=0 and ld_data_valid=0 in every state except DONE-load. ld_data holds its last value otherwise.
- mem_rsp_valid outside WAIT_RSP is ignored, including a response from a transaction cut off by reset. Responses are guaranteed no earlier than the cycle after the request handshake.
- Store formatting:
  - byte: wdata={4{op_wdata[7:0]}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{op_wdata[15:0]}}, be=4'b0011<<{addr[1],1'b0}.
  - word: wdata=op_wdata, be=4'b1111.
- Load requests use be=4'b1111 and wdata=0.
- Load formatting: lane=rsp>>(8*addr[1:0]).
  - byte: ext(lane[7:0]).
  - half: ext(lane[15:0]).
  - word: unchanged.
  - ext is sign extension unless op_unsigned=1.
- Latency, load with ready=1 and response one cycle after handshake: accept in C0, handshake in C1, response in C2, ld_data_valid in C3. stall high C0–C2.
- Latency, store with ready=1: stall high C0–C1, DONE in C2.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, no ld_data_valid pulse.

Test Plan:
- Word load @0x100, ready=1, response 0xDEADBEEF 1 cycle later -> req addr 0x100, be=1111, we=0; stall 3 cycles; ld_data=0xDEADBEEF with ld_data_valid=wb_sel=1 for exactly 1 cycle.
- LB @0x103, signed, response 0x80112233 -> ld_data=0xFFFFFF80. Same with op_unsigned=1 -> 0x00000080.
- SH @0x102, wdata 0x0000ABCD -> addr 0x100, be=1100, wdata=0xABCDABCD, we=1. DONE reached with no response; wb_sel stays 0.
- LW @0x101 -> misaligned pulse 1 cycle, mem_req_valid never asserted, stall=0.
- Load with mem_req_ready low 3 cycles -> mem_req_valid and addr/be stable for 4 cycles; stall held; completes after the response. A stray mem_rsp_valid during REQ is ignored.
- rst_n low during WAIT_RSP -> all outputs 0 asynchronously. A later mem_rsp_valid is ignored. The next op completes normally.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: memory-stage load/store controller.
// Accepts one load/store from the M stage, issues a single request on a
// valid/ready channel, waits for the read response when it is a load, and
// stalls the pipeline until the op completes. Formats store data/byte enables
// and aligns/extends load data.
//
// Ports:
//   clk, rst_n          core clock, async active-low reset
//   op_*                M-stage memory op (held stable while stall=1)
//   mem_req_*           request channel (valid/ready)
//   mem_rsp_*           read response (one-cycle pulse)
//   stall               hold upstream pipeline
//   ld_data(_valid)     aligned/extended load result and its one-cycle pulse
//   wb_sel              M-stage mux select, 1 = load result
//   misaligned          one-cycle exception pulse for misaligned/illegal ops
module dmem_ctrl #(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              op_we,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [DATA_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [BE_W-1:0]   mem_req_be,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_data_valid,
  output logic              wb_sel,
  output logic              misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t      state;
  logic [1:0]  off_q;   // byte offset of the accepted op
  logic [1:0]  size_q;
  logic        uns_q;

  // ---------------- alignment ----------------
  logic aligned;
  always_comb begin
    aligned = 1'b0;
    unique case (op_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~op_addr[0];
      2'b10:   aligned = (op_addr[1:0] == 2'b00);
      default: aligned = 1'b0;   // size 11 is illegal
    endcase
  end

  // ---------------- store formatting ----------------
  // Each byte lane picks its source byte: byte ops replicate byte 0,
  // half ops replicate the low halfword, word ops pass through.
  logic [BE_W-1:0][7:0] st_bytes;
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign st_bytes[i] = (op_size == 2'b00) ? op_wdata[7:0] :
                         (op_size == 2'b01) ? op_wdata[8*(i%2) +: 8] :
                                              op_wdata[8*i +: 8];
  end

  logic [BE_W-1:0] st_be;
  always_comb begin
    st_be = {BE_W{1'b1}};
    unique case (op_size)
      2'b00:   st_be = 4'b0001 << op_addr[1:0];
      2'b01:   st_be = 4'b0011 << {op_addr[1], 1'b0};
      default: st_be = {BE_W{1'b1}};
    endcase
  end

  // ---------------- load formatting ----------------
  logic [DATA_W-1:0] lane, ld_fmt;
  assign lane = mem_rsp_data >> {off_q, 3'b000};
  always_comb begin
    ld_fmt = lane;
    unique case (size_q)
      2'b00:   ld_fmt = {{(DATA_W-8){~uns_q & lane[7]}},   lane[7:0]};
      2'b01:   ld_fmt = {{(DATA_W-16){~uns_q & lane[15]}}, lane[15:0]};
      default: ld_fmt = lane;
    endcase
  end

  // ---------------- combinational handshake outputs ----------------
  // Gated by rst_n so every output reads 0 while reset is held, even with
  // op_valid still asserted upstream.
  assign stall      = rst_n & (((state == IDLE) & op_valid & aligned) |
                               (state == REQ) | (state == WAIT_RSP));
  assign misaligned = rst_n & (state == IDLE) & op_valid & ~aligned;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      off_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_be    <= '0;
      mem_req_wdata <= '0;
      ld_data       <= '0;
      ld_data_valid <= 1'b0;
      wb_sel        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (op_valid && aligned) begin
            off_q         <= op_addr[1:0];
            size_q        <= op_size;
            uns_q         <= op_unsigned;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {op_addr[DATA_W-1:2], 2'b00};
            mem_req_we    <= op_we;
            mem_req_be    <= op_we ? st_be : {BE_W{1'b1}};
            mem_req_wdata <= op_we ? st_bytes : '0;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= mem_req_we ? DONE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            ld_data       <= ld_fmt;
            ld_data_valid <= 1'b1;
            wb_sel        <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // op_valid here belongs to the completing op; never re-accept it.
          ld_data_valid <= 1'b0;
          wb_sel        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
